// File: rtl/parity_pkg.sv
// Shared FSM state type, expected tester response bytes and LFSR feedback taps
// for the parity stimulus generator.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RSP = 2'd2,
    REPORT   = 2'd3
  } state_t;

  localparam logic [7:0] RSP_ODD   = 8'hFF;
  localparam logic [7:0] RSP_EVEN0 = 8'hAB;
  localparam logic [7:0] RSP_EVEN1 = 8'h12;
  localparam logic [7:0] RSP_EVEN2 = 8'hDE;

  // Feedback from bits 7,5,4,3 shifted into bit 0.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/parity_stimulus_lfsr8.sv
// 8-bit Fibonacci LFSR: load wins over enable, q is the registered current byte.
// Zero latency from q to the payload bus; advances only when enable is asserted.
module lfsr8
  import parity_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       enable,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= 8'h00;
    end else if (load) begin
      r_q <= seed;
    end else if (enable) begin
      r_q <= {r_q[6:0], ^(r_q & LFSR_TAPS)};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/parity_stimulus.sv
// Sends one LFSR payload packet to a parity tester, checks its reply, and reports pass/timeout.
// Payload beats hold under axis_m_tready=0; response is consumed only while waiting for it.
module parity_stimulus
  import parity_pkg::*;
#(
  parameter int RSP_TIMEOUT = 1023,
  parameter int CNT_W       = 16
) (
  input  logic             a_clk,
  input  logic             axis_aresetn,
  input  logic             start,
  input  logic [7:0]       pkt_len,
  input  logic [7:0]       seed,
  output logic             axis_m_tvalid,
  output logic [7:0]       axis_m_tdata,
  input  logic             axis_m_tready,
  output logic             axis_m_tlast,
  input  logic             axis_s_tvalid,
  input  logic [7:0]       axis_s_tdata,
  output logic             axis_s_tready,
  input  logic             axis_s_tlast,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int TMO_W = (RSP_TIMEOUT < 1) ? 1 : $clog2(RSP_TIMEOUT + 1);

  state_t           r_state;
  logic             r_m_tvalid;
  logic             r_m_tlast;
  logic             r_s_tready;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_timeout;
  logic             r_parity;
  logic [7:0]       r_rem;
  logic [1:0]       r_rsp_idx;
  logic [TMO_W-1:0] r_tmo;
  logic [CNT_W-1:0] r_pkt_count;
  logic [CNT_W-1:0] r_err_count;

  logic [7:0] w_lfsr_q;
  logic [7:0] w_seed_eff;
  logic [7:0] w_len_eff;
  logic [7:0] w_exp_dat;
  logic       w_exp_last;
  logic       w_start_acc;
  logic       w_m_acc;
  logic       w_s_acc;
  logic       w_rsp_bad;
  logic       w_rsp_good;
  logic       w_tmo_hit;
  logic       w_end;

  assign w_start_acc = start && (r_state == IDLE);
  assign w_m_acc     = r_m_tvalid && axis_m_tready;
  assign w_s_acc     = axis_s_tvalid && r_s_tready;
  assign w_seed_eff  = (seed == 8'h00) ? 8'h01 : seed;
  assign w_len_eff   = (pkt_len == 8'h00) ? 8'h01 : pkt_len;

  lfsr8 u_lfsr (
    .clk    (a_clk),
    .rst_n  (axis_aresetn),
    .load   (w_start_acc),
    .enable (w_m_acc),
    .seed   (w_seed_eff),
    .q      (w_lfsr_q)
  );

  // Expected response beat for the current position, chosen by payload parity.
  always_comb begin
    w_exp_dat  = RSP_ODD;
    w_exp_last = 1'b1;
    if (!r_parity) begin
      case (r_rsp_idx)
        2'd0:    begin w_exp_dat = RSP_EVEN0; w_exp_last = 1'b0; end
        2'd1:    begin w_exp_dat = RSP_EVEN1; w_exp_last = 1'b0; end
        default: begin w_exp_dat = RSP_EVEN2; w_exp_last = 1'b1; end
      endcase
    end
  end

  assign w_rsp_bad  = w_s_acc && ((axis_s_tdata != w_exp_dat) || (axis_s_tlast != w_exp_last));
  assign w_rsp_good = w_s_acc && !w_rsp_bad && w_exp_last;
  assign w_tmo_hit  = (r_state == WAIT_RSP) && !w_s_acc && (r_tmo == TMO_W'(RSP_TIMEOUT));
  assign w_end      = w_rsp_bad || w_rsp_good || w_tmo_hit;

  always_ff @(posedge a_clk) begin
    if (!axis_aresetn) begin
      r_state     <= IDLE;
      r_m_tvalid  <= 1'b0;
      r_m_tlast   <= 1'b0;
      r_s_tready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_parity    <= 1'b0;
      r_rem       <= 8'h00;
      r_rsp_idx   <= 2'd0;
      r_tmo       <= '0;
      r_pkt_count <= '0;
      r_err_count <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_acc) begin
            r_state    <= SEND;
            r_busy     <= 1'b1;
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= (w_len_eff == 8'd1);
            r_rem      <= w_len_eff;
            r_parity   <= 1'b0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
          end
        end
        SEND: begin
          if (w_m_acc) begin
            r_parity <= r_parity ^ (^w_lfsr_q);
            if (r_m_tlast) begin
              r_state    <= WAIT_RSP;
              r_m_tvalid <= 1'b0;
              r_m_tlast  <= 1'b0;
              r_s_tready <= 1'b1;
              r_tmo      <= '0;
              r_rsp_idx  <= 2'd0;
            end else begin
              r_rem     <= r_rem - 8'd1;
              r_m_tlast <= (r_rem == 8'd2);
            end
          end
        end
        WAIT_RSP: begin
          if (w_end) begin
            r_state     <= REPORT;
            r_s_tready  <= 1'b0;
            r_done      <= 1'b1;
            r_pass      <= w_rsp_good;
            r_timeout   <= w_tmo_hit;
            r_pkt_count <= r_pkt_count + CNT_W'(1);
            if (!w_rsp_good && (r_err_count != {CNT_W{1'b1}})) begin
              r_err_count <= r_err_count + CNT_W'(1);
            end
          end else if (w_s_acc) begin
            r_rsp_idx <= r_rsp_idx + 2'd1;
            r_tmo     <= '0;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        REPORT: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign axis_m_tvalid = r_m_tvalid;
  assign axis_m_tdata  = w_lfsr_q;
  assign axis_m_tlast  = r_m_tlast;
  assign axis_s_tready = r_s_tready;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign timeout       = r_timeout;
  assign pkt_count     = r_pkt_count;
  assign err_count     = r_err_count;

endmodule

// File: doc/parity_stimulus.md
PARITY_STIMULUS -- requirements
Module: parity_stimulus

Interface
REQ-001 SHALL have parameter RSP_TIMEOUT, default 1023; this is the max a_clk cycles spent in WAIT_RSP before declaring timeout.
REQ-002 SHALL have parameter CNT_W, default 16; this is the width of the packet and error counters.
REQ-003 a_clk  in  1  sole clock; all logic on rising edge.
REQ-004 axis_aresetn  in  1  reset; synchronous, active-low.
REQ-005 start  in  1  single-cycle request to send one packet; ignored unless busy=0.
REQ-006 pkt_len  in  8  payload beat count, sampled on accepted start; 0 treated as 1.
REQ-007 seed  in  8  LFSR start value, sampled on accepted start; 0x00 replaced by 0x01.
REQ-008 axis_m_tvalid / axis_m_tdata[7:0] / axis_m_tready / axis_m_tlast  out/out/in/out  AXI-Stream master carrying the payload to the parity tester.
REQ-009 axis_s_tvalid / axis_s_tdata[7:0] / axis_s_tready / axis_s_tlast  in/in/out/in  AXI-Stream slave receiving the tester response.
REQ-010 busy  out  1  high from accepted start until done.
REQ-011 done  out  1  one-cycle pulse at end of each transaction.
REQ-012 pass  out  1  result of last transaction, valid from done until next start.
REQ-013 timeout  out  1  last transaction ended by timeout, valid with pass.
REQ-014 pkt_count  out  CNT_W  transactions completed, wraps.
REQ-015 err_count  out  CNT_W  failed transactions, saturates at all-ones.

Function
REQ-016 FSM states SHALL be IDLE, SEND, WAIT_RSP, REPORT; IDLE->SEND on start; SEND->WAIT_RSP on accepted last beat; WAIT_RSP->REPORT on accepted response tlast, mismatch, or timeout; REPORT->IDLE after one cycle with done=1.
REQ-017 Payload byte 0 SHALL equal the effective seed; each later byte = {prev[6:0], prev[7]^prev[5]^prev[4]^prev[3]}.
REQ-018 A beat SHALL be accepted only when axis_m_tvalid && axis_m_tready.
REQ-019 The LFSR and the beat counter SHALL advance only on acceptance.
REQ-020 axis_m_tvalid SHALL be high throughout SEND.
REQ-021 axis_m_tdata/axis_m_tlast SHALL be held stable while tvalid && !tready.
REQ-022 axis_m_tlast SHALL be high only on beat pkt_len.
REQ-023 Running parity SHALL be the XOR-reduction of all accepted payload bytes; it clears on accepted start.
REQ-024 Expected response when parity is odd: one beat 0xFF with tlast=1.
REQ-025 Expected response when parity is even: 0xAB, 0x12, 0xDE, with tlast=1 only on 0xDE.
REQ-026 axis_s_tready SHALL be 1 only in WAIT_RSP.
REQ-027 A response beat is accepted when axis_s_tvalid && axis_s_tready.
REQ-028 Any data mismatch or tlast position mismatch SHALL end WAIT_RSP immediately with pass=0.
REQ-029 The timeout counter SHALL clear on WAIT_RSP entry and on each accepted response beat.
REQ-030 Reaching RSP_TIMEOUT SHALL end WAIT_RSP with pass=0 and timeout=1.
REQ-031 In REPORT, pkt_count SHALL increment; err_count SHALL increment if pass=0.
REQ-032 start while busy SHALL be ignored.
REQ-033 start and done in the same cycle: start SHALL be ignored.
REQ-034 Response beats arriving outside WAIT_RSP SHALL not be consumed (tready=0).

Reset
REQ-035 When axis_aresetn=0 at a rising edge, the following SHALL clear to 0: state=IDLE, all outputs (axis_m_tvalid, axis_m_tlast, axis_m_tdata, axis_s_tready, busy, done, pass, timeout), both counters, parity, and the LFSR.
REQ-036 Reset mid-transaction SHALL abort immediately with no done pulse.

Structure
REQ-037 Shared package parity_pkg SHALL hold the FSM state enum, the response bytes RSP_ODD=0xFF and RSP_EVEN0..2=0xAB/0x12/0xDE, and the LFSR tap mask.
REQ-038 One sub-module lfsr8 (load, enable, seed, q) SHALL be instantiated; all else stays in parity_stimulus.

Verification
REQ-039 Scenario (odd): seed 0x01, len 1, tready=1 -> master sends 0x01 with tlast; tester model replies 0xFF/tlast -> done, pass=1, pkt_count=1.
REQ-040 Scenario (even): seed 0x01, len 2 -> master sends 0x01, 0x02 (tlast on 0x02); model replies AB,12,DE -> pass=1.
REQ-041 Scenario (backpressure): len 4, tready toggles every cycle -> 0x01, 0x02, 0x04, 0x08 each held stable until accepted, no duplicates or drops.
REQ-042 Scenario (mismatch): seed 0x01, len 1; model replies 0xAB -> pass=0, err_count=1, WAIT_RSP exits on that beat.
REQ-043 Scenario (timeout): RSP_TIMEOUT=15, no response -> done 16-17 cycles after WAIT_RSP entry, timeout=1, pass=0.
REQ-044 Scenario (reset/start edge cases): reset asserted during beat 2 of 4 -> all outputs 0 next cycle; then seed 0x00, len 0 -> one beat 0x01 with tlast.
